// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle shared by the frame sources, the TX arbiter and uart_controller.
// The master modport is the arbiter's view; slave is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
);
    logic [N_REQ-1:0]            req_vld;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ack;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic                        tx_vld;
    logic                        tx_rdy;
    logic [ID_WIDTH-1:0]         grant_id;
    logic                        busy;
    logic                        err_timeout;

    modport master (
        input  req_vld, req_data, tx_rdy,
        output req_ack, tx_data, tx_vld, grant_id, busy, err_timeout
    );

    modport slave (
        output req_vld, req_data, tx_rdy,
        input  req_ack, tx_data, tx_vld, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_controller TX channel among N_REQ frame sources,
// with bounded bursts per grant and a timeout for a transmitter that never goes busy.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 2,
    parameter int MAX_BURST    = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int unsigned         NREQ_U     = N_REQ;
    localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(N_REQ - 1);
    localparam logic [7:0]          BURST_LAST = 8'(MAX_BURST - 1);
    // The pulse is registered, so the hit is flagged one count early to land
    // err_timeout exactly BUSY_TIMEOUT cycles after ISSUE.
    localparam logic [15:0]         TMO_LAST   = 16'(BUSY_TIMEOUT - 2);

    state_t                r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic [7:0]            r_burst_cnt;
    logic [15:0]           r_tmo_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [N_REQ-1:0]      r_req_ack;
    logic                  r_tx_vld;
    logic                  r_busy;
    logic                  r_err_timeout;

    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_winner;
    logic [N_REQ-1:0]      w_win_oh;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_capture;
    logic                  w_tmo_hit;
    logic                  w_done;

    // Winner is the valid requester at the smallest wrapped distance from the pointer.
    always_comb begin
        int unsigned w_best;
        int unsigned w_dist;
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_oh   = '0;
        w_win_data = '0;
        w_best     = NREQ_U;
        w_dist     = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (i >= 32'(r_ptr)) w_dist = i - 32'(r_ptr);
            else                 w_dist = i + NREQ_U - 32'(r_ptr);
            if (bus.req_vld[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_winner    = ID_WIDTH'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_tmo_hit   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ARB: begin
                if (bus.tx_rdy && w_found) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!bus.tx_rdy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ARB;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_rdy) begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_burst_cnt   <= '0;
            r_tmo_cnt     <= '0;
            r_tx_data     <= '0;
            r_req_ack     <= '0;
            r_tx_vld      <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_tx_vld      <= w_capture;
            r_req_ack     <= w_capture ? w_win_oh : '0;
            r_err_timeout <= w_tmo_hit;
            r_busy        <= (w_state_nxt != ARB);

            if (w_capture) begin
                r_tx_data  <= w_win_data;
                r_grant_id <= w_winner;
                if (w_winner != r_grant_id) r_burst_cnt <= '0;
            end

            if (r_state == ISSUE)                          r_tmo_cnt <= '0;
            else if ((r_state == WAIT_BUSY) && bus.tx_rdy) r_tmo_cnt <= r_tmo_cnt + 16'd1;

            // A timed-out frame never reaches here, so pointer and burst stay put.
            if (w_done) begin
                if (r_burst_cnt == BURST_LAST) begin
                    r_ptr       <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
                    r_burst_cnt <= '0;
                end else begin
                    r_ptr       <= r_grant_id;
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.req_ack     = r_req_ack;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_vld      = r_tx_vld;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of arbitration scenarios plus hand-written corner
// sequences, checked against a frame scoreboard and a behavioural TX-ready model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int MB = 2;
    localparam int BT = 16;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    // ids: frame k's expected grant in nibble k
    typedef struct packed {
        logic [NR-1:0] mask;
        logic [7:0]    busy_len;
        logic [3:0]    n;
        logic [39:0]   ids;
    } vec_t;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    uart_tx_arbiter #(
        .N_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t          sb[$];
    vec_t          vecs[6];
    int unsigned   checks = 0;
    int unsigned   fails = 0;
    int unsigned   cyc = 0;
    int unsigned   fcnt[NR];
    logic [NR-1:0] mask;
    int unsigned   left;
    int unsigned   busy_len;
    bit            uart_stuck;
    int unsigned   fall_in, rise_in;
    int unsigned   ref_cyc, ref_lat;
    int unsigned   last_issue, err_cnt, err_cyc;

    function automatic logic [DW-1:0] frame(input int unsigned i, input int unsigned k);
        logic [3:0] nib;
        nib = 4'(i + 1);
        return {16{nib}} ^ (64'(k) << 40) ^ 64'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int unsigned i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = frame(i, fcnt[i]);
        bus.req_vld = (left != 0) ? mask : '0;
    endtask

    task automatic push(input int unsigned id);
        exp_t e;
        int unsigned k;
        k = fcnt[id];
        foreach (sb[j]) if (sb[j].id == IW'(id)) k++;
        e.id   = IW'(id);
        e.data = frame(id, k);
        sb.push_back(e);
    endtask

    // One cycle: sample at negedge, score outputs, advance requester and uart models.
    task automatic step();
        logic rdy_prev;
        exp_t e;
        @(negedge clk);
        cyc++;
        rdy_prev = bus.tx_rdy;
        if (bus.err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.tx_vld || (bus.req_ack != '0)) begin
            chk("ack_onehot", 64'(bus.req_ack), 64'(bus.tx_vld) << bus.grant_id);
            if (bus.tx_vld) begin
                chk("rdy_at_capture", 64'(rdy_prev), 64'd1);
                chk("busy_in_issue", 64'(bus.busy), 64'd1);
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: got grant %0d, want no issue at cycle %0d",
                             bus.grant_id, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", 64'(bus.grant_id), 64'(e.id));
                    chk("tx_data", bus.tx_data, e.data);
                end
                if (ref_lat != 0) chk("issue_latency", 64'(cyc - ref_cyc), 64'(ref_lat));
                ref_lat    = 0;
                last_issue = cyc;
                if (left != 0) left--;
            end
            for (int unsigned i = 0; i < NR; i++) if (bus.req_ack[i]) fcnt[i]++;
        end
        if (fall_in != 0) begin
            fall_in--;
            if (fall_in == 0) begin
                bus.tx_rdy = 1'b0;
                rise_in    = busy_len;
            end
        end else if (rise_in != 0) begin
            rise_in--;
            if (rise_in == 0) begin
                bus.tx_rdy = 1'b1;
                ref_cyc    = cyc;
                ref_lat    = 2;
            end
        end
        if (bus.tx_vld && !uart_stuck) fall_in = 2;
        drive();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".tx_vld"},      64'(bus.tx_vld), 64'd0);
        chk({tag, ".req_ack"},     64'(bus.req_ack), 64'd0);
        chk({tag, ".tx_data"},     bus.tx_data, 64'd0);
        chk({tag, ".grant_id"},    64'(bus.grant_id), 64'd0);
        chk({tag, ".busy"},        64'(bus.busy), 64'd0);
        chk({tag, ".err_timeout"}, 64'(bus.err_timeout), 64'd0);
    endtask

    task automatic uart_idle();
        fall_in    = 0;
        rise_in    = 0;
        uart_stuck = 1'b0;
        bus.tx_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_idle();
        left    = 0;
        ref_lat = 0;
        err_cnt = 0;
        drive();
        #1;
        check_idle("reset");
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start();
        drive();
        ref_cyc = cyc;
        ref_lat = 1;
    endtask

    task automatic finish_scn(input string tag, input int unsigned exp_err);
        int unsigned n;
        n = 0;
        while (!((left == 0) && (sb.size() == 0) && bus.tx_rdy && !bus.busy) && (n < 2000)) begin
            step();
            n++;
        end
        step();
        step();
        chk({tag, ".frames_left"}, 64'(sb.size()), 64'd0);
        chk({tag, ".timeouts"}, 64'(err_cnt), 64'(exp_err));
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{4'b0010, 8'd100, 4'd3,  40'h111};
        vecs[1] = '{4'b1111, 8'd4,   4'd10, 40'h00_3322_1100};
        vecs[2] = '{4'b0101, 8'd5,   4'd6,  40'h002200};
        vecs[3] = '{4'b1010, 8'd3,   4'd6,  40'h113311};
        vecs[4] = '{4'b1000, 8'd6,   4'd3,  40'h333};
        vecs[5] = '{4'b1100, 8'd4,   4'd5,  40'h23322};

        rst_n = 1'b1;
        mask  = '0;
        left  = 0;
        busy_len = 4;
        ref_lat  = 0;
        err_cnt  = 0;
        for (int unsigned i = 0; i < NR; i++) fcnt[i] = 0;
        uart_idle();
        drive();

        for (int unsigned v = 0; v < 6; v++) begin
            do_reset();
            busy_len = 32'(vecs[v].busy_len);
            mask     = vecs[v].mask;
            left     = 32'(vecs[v].n);
            for (int unsigned k = 0; k < 32'(vecs[v].n); k++) push(32'(vecs[v].ids[k*4 +: 4]));
            start();
            finish_scn($sformatf("vec%0d", v), 0);
        end

        // Request arrives while the transmitter is busy: nothing until tx_rdy rises.
        do_reset();
        busy_len   = 4;
        bus.tx_rdy = 1'b0;
        mask       = 4'b0001;
        left       = 1;
        push(0);
        drive();
        for (int unsigned n = 0; n < 6; n++) begin
            step();
            chk("hold_while_not_rdy", 64'({bus.tx_vld, bus.req_ack}), 64'd0);
        end
        bus.tx_rdy = 1'b1;
        ref_cyc    = cyc;
        ref_lat    = 1;
        finish_scn("rdy_low", 0);

        // Transmitter never goes busy: timeout, no burst/pointer update, next frame issued.
        do_reset();
        busy_len   = 4;
        uart_stuck = 1'b1;
        mask       = 4'b0110;
        left       = 4;
        push(1); push(1); push(1); push(2);
        start();
        for (int unsigned n = 0; (n < 60) && (err_cnt == 0); n++) step();
        chk("timeout_seen", 64'(err_cnt), 64'd1);
        chk("timeout_delay", 64'(err_cyc - last_issue), 64'(BT));
        chk("arb_after_timeout", 64'(bus.busy), 64'd0);
        uart_stuck = 1'b0;
        step();
        chk("timeout_one_cycle", 64'(bus.err_timeout), 64'd0);
        chk("reissue_after_timeout", 64'(bus.tx_vld), 64'd1);
        finish_scn("timeout", 1);

        // Asynchronous reset in WAIT_DONE, then pointer must restart from 0.
        do_reset();
        busy_len = 30;
        mask     = 4'b0100;
        left     = 2;
        push(2); push(2);
        start();
        for (int unsigned n = 0; (n < 200) && !((left == 0) && (bus.tx_rdy == 1'b0)); n++) step();
        step();
        chk("in_wait_done", 64'(bus.busy), 64'd1);
        chk("wait_done_grant", 64'(bus.grant_id), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        chk("frames_before_reset", 64'(sb.size()), 64'd0);
        uart_idle();
        mask = 4'b1001;
        left = 3;
        push(0); push(0); push(3);
        drive();
        step();
        chk("no_issue_in_reset", 64'({bus.tx_vld, bus.req_ack}), 64'd0);
        step();
        rst_n   = 1'b1;
        ref_cyc = cyc;
        ref_lat = 1;
        finish_scn("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
